vx_mem_responder: RTL

//  Memory-side responder for the VX_MEM request/response interface driven by the GPU top level.

---
 rtl/vx_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vx_mem_responder.sv
// Line-wide memory endpoint: byte-masked writes, fixed-latency in-order tagged reads.
// Optional perf counters when VX_MEM_RSP_PERF_EN is defined.
module vx_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 4,
    parameter int RSPQ_SIZE      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy
`ifdef VX_MEM_RSP_PERF_EN
    ,
    output logic [31:0]             perf_reads,
    output logic [31:0]             perf_writes,
    output logic [31:0]             perf_stalls
`endif
);

    localparam int BW    = DATA_WIDTH / 8;
    localparam int QW    = $clog2(RSPQ_SIZE);
    localparam int PW    = QW + 1;
    localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     ram [DEPTH];
    logic [RAM_ADDR_WIDTH-1:0] idx;
    logic [PW-1:0]             pending;
    logic                      req_fire, rd_fire, wr_fire, rsp_fire;
    logic                      push_valid;
    logic [DATA_WIDTH-1:0]     push_data;
    logic [TAG_WIDTH-1:0]      push_tag;

    assign idx      = mem_req_addr[RAM_ADDR_WIDTH-1:0];
    assign req_fire = mem_req_valid && mem_req_ready;
    assign rd_fire  = req_fire && !mem_req_rw;
    assign wr_fire  = req_fire && mem_req_rw;
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    // Credits: pending covers pipeline plus FIFO, so the FIFO can never overflow.
    assign mem_req_ready = reset && (pending != PW'(RSPQ_SIZE));
    assign busy          = reset && (pending != '0);

    generate
        if (RAM_ADDR_WIDTH < ADDR_WIDTH) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BW; i++) begin
                if (mem_req_byteen[i])
                    ram[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (rd_fire && !rsp_fire) begin
            pending <= pending + PW'(1);
        end else if (!rd_fire && rsp_fire) begin
            pending <= pending - PW'(1);
        end
    end

    // The request cycle is stage 0, so only LATENCY-1 register stages are needed.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign push_valid = rd_fire;
            assign push_data  = ram[idx];
            assign push_tag   = mem_req_tag;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic                  pv [NS];
            logic [DATA_WIDTH-1:0] pd [NS];
            logic [TAG_WIDTH-1:0]  pt [NS];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < NS; i++) pv[i] <= 1'b0;
                end else begin
                    pv[0] <= rd_fire;
                    for (int i = 1; i < NS; i++) pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pd[0] <= ram[idx];
                pt[0] <= mem_req_tag;
                for (int i = 1; i < NS; i++) begin
                    pd[i] <= pd[i-1];
                    pt[i] <= pt[i-1];
                end
            end

            assign push_valid = pv[NS-1];
            assign push_data  = pd[NS-1];
            assign push_tag   = pt[NS-1];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] q_data [RSPQ_SIZE];
    logic [TAG_WIDTH-1:0]  q_tag  [RSPQ_SIZE];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_valid) wr_ptr <= wr_ptr + PW'(1);
            if (rsp_fire)   rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid) begin
            q_data[wr_ptr[QW-1:0]] <= push_data;
            q_tag[wr_ptr[QW-1:0]]  <= push_tag;
        end
    end

    assign mem_rsp_valid = reset && (wr_ptr != rd_ptr);
    assign mem_rsp_data  = q_data[rd_ptr[QW-1:0]];
    assign mem_rsp_tag   = q_tag[rd_ptr[QW-1:0]];

`ifdef VX_MEM_RSP_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (rd_fire) perf_reads <= perf_reads + 32'd1;
            if (wr_fire) perf_writes <= perf_writes + 32'd1;
            if (mem_req_valid && !mem_req_ready)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
